// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types for the registered accumulator ALU: the 4-bit operation
// encoding issued by the instruction decoder and the sequencer states.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int ALU_OPW = 4;

   // Operation codes as issued by the decoder; 13-15 are unassigned.
   typedef enum logic [ALU_OPW-1:0] {
      OP_ADD = 4'd0,
      OP_ADC = 4'd1,
      OP_SUB = 4'd2,
      OP_SBC = 4'd3,
      OP_AND = 4'd4,
      OP_OR  = 4'd5,
      OP_XOR = 4'd6,
      OP_NOT = 4'd7,
      OP_LD  = 4'd8,
      OP_MUL = 4'd9,
      OP_SHL = 4'd10,
      OP_SHR = 4'd11,
      OP_CLR = 4'd12
   } op_e;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      SHIFT
   } state_e;

endpackage

// File: rtl/alu_accu_seq_if.sv
// -----------------------------------------------------------------------------
// alu_accu_seq_if
// Control-unit <-> ALU bundle.
//   master (control unit): drives op_valid, op_code, operand;
//                          observes op_ready, done, illegal, acc, acc_hi, flags.
//   slave  (ALU)         : the mirror image.
// -----------------------------------------------------------------------------
interface alu_accu_seq_if
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
);
   logic                 op_valid;
   logic [ALU_OPW-1:0]   op_code;
   logic [WIDTH-1:0]     operand;
   logic                 op_ready;
   logic                 done;
   logic                 illegal;
   logic [WIDTH-1:0]     acc;
   logic [WIDTH-1:0]     acc_hi;
   logic                 flag_c;
   logic                 flag_z;
   logic                 flag_n;

   modport master (
      output op_valid, op_code, operand,
      input  op_ready, done, illegal, acc, acc_hi, flag_c, flag_z, flag_n
   );

   modport slave (
      input  op_valid, op_code, operand,
      output op_ready, done, illegal, acc, acc_hi, flag_c, flag_z, flag_n
   );
endinterface

// File: rtl/alu_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq
// Unsigned shift-add multiplier, one partial product per clock.
//   clk, rst_n  : clock, async active-low reset
//   start_i     : load operands (one cycle); WIDTH iterations follow
//   mcand_i     : multiplicand
//   mplier_i    : multiplier
//   busy_o      : iterations still pending
//   done_o      : final iteration happens at the coming edge; product_o is
//                 the full product at that edge
//   product_o   : value {hi,lo} takes at the next iteration edge
// -----------------------------------------------------------------------------
module alu_mul_seq #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic [WIDTH-1:0]     mcand_i,
   input  logic [WIDTH-1:0]     mplier_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [2*WIDTH-1:0]   product_o
);
   localparam int CNTW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] mcand_q, hi_q, lo_q;
   logic [CNTW-1:0]  cnt_q;
   logic [WIDTH:0]   sum;

   // Add the multiplicand into the high half when the current multiplier
   // bit is set, then shift the whole {carry,hi,lo} right by one.
   assign sum       = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
   assign product_o = {sum, lo_q[WIDTH-1:1]};
   assign busy_o    = (cnt_q != '0);
   assign done_o    = (cnt_q == CNTW'(1));

   // NOTE: sequential state is written with <= so every flop samples the
   // pre-edge values; blocking assignments here would create order races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
      end else if (start_i) begin
         mcand_q <= mcand_i;
         hi_q    <= '0;
         lo_q    <= mplier_i;
         cnt_q   <= CNTW'(WIDTH);
      end else if (busy_o) begin
         {hi_q, lo_q} <= product_o;
         cnt_q        <= cnt_q - CNTW'(1);
      end
   end
endmodule

// File: rtl/alu_accu_seq.sv
// -----------------------------------------------------------------------------
// alu_accu_seq
// Registered accumulator ALU with C/Z/N flags. Single-cycle arithmetic and
// logic ops, multi-cycle MUL (WIDTH cycles) and one-bit-per-cycle shifts.
//   clk, rst_n : clock, async active-low reset (aborts any op in flight)
//   bus        : alu_accu_seq_if.slave
//                in : op_valid, op_code, operand
//                out: op_ready, done, illegal, acc, acc_hi, flag_c/z/n
// -----------------------------------------------------------------------------
module alu_accu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_accu_seq_if.slave bus
);
   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d, acc_hi_q, acc_hi_d, work_q, work_d;
   logic             c_q, c_d, z_q, z_d, n_q, n_d;
   logic             done_q, done_d, illegal_q, illegal_d;
   logic [SHW-1:0]   shcnt_q, shcnt_d;
   logic             shr_q, shr_d;

   op_e                op;
   logic [SHW-1:0]     shamt;
   logic [WIDTH:0]     cin, wide;
   logic [WIDTH-1:0]   shifted;
   logic               bit_out;
   logic               mul_start, mul_busy, mul_done;
   logic [2*WIDTH-1:0] product;

   alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (mul_start),
      .mcand_i   (acc_q),
      .mplier_i  (bus.operand),
      .busy_o    (mul_busy),
      .done_o    (mul_done),
      .product_o (product)
   );

   assign op      = op_e'(bus.op_code);
   assign shamt   = bus.operand[SHW-1:0];
   assign cin     = {{WIDTH{1'b0}}, c_q};
   assign shifted = shr_q ? {1'b0, work_q[WIDTH-1:1]} : {work_q[WIDTH-2:0], 1'b0};
   assign bit_out = shr_q ? work_q[0] : work_q[WIDTH-1];

   // NOTE: every signal assigned in this block gets a default first, so no
   // path through the case statements can leave it unassigned (no latches).
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      acc_hi_d  = acc_hi_q;
      c_d       = c_q;
      z_d       = z_q;
      n_d       = n_q;
      done_d    = 1'b0;
      illegal_d = 1'b0;
      work_d    = work_q;
      shcnt_d   = shcnt_q;
      shr_d     = shr_q;
      mul_start = 1'b0;
      wide      = '0;

      case (state_q)
         IDLE: begin
            if (bus.op_valid) begin
               done_d = 1'b1;
               case (op)
                  OP_ADD: wide = {1'b0, acc_q} + {1'b0, bus.operand};
                  OP_ADC: wide = {1'b0, acc_q} + {1'b0, bus.operand} + cin;
                  // Bit WIDTH of the difference is the borrow.
                  OP_SUB: wide = {1'b0, acc_q} - {1'b0, bus.operand};
                  OP_SBC: wide = {1'b0, acc_q} - {1'b0, bus.operand} - cin;
                  OP_AND: wide = {1'b0, acc_q & bus.operand};
                  OP_OR:  wide = {1'b0, acc_q | bus.operand};
                  OP_XOR: wide = {1'b0, acc_q ^ bus.operand};
                  OP_NOT: wide = {1'b0, ~acc_q};
                  OP_LD:  wide = {1'b0, bus.operand};
                  OP_CLR: wide = '0;
                  OP_MUL: begin
                     wide      = {1'b0, acc_q};
                     done_d    = 1'b0;
                     mul_start = 1'b1;
                     state_d   = MUL;
                  end
                  OP_SHL, OP_SHR: begin
                     // A zero shift finishes now: acc kept, C cleared.
                     wide = {1'b0, acc_q};
                     if (shamt != '0) begin
                        done_d  = 1'b0;
                        work_d  = acc_q;
                        shcnt_d = shamt;
                        shr_d   = (op == OP_SHR);
                        state_d = SHIFT;
                     end
                  end
                  default: begin
                     wide      = {c_q, acc_q};
                     illegal_d = 1'b1;
                  end
               endcase
               if (done_d && !illegal_d) begin
                  acc_d = wide[WIDTH-1:0];
                  c_d   = wide[WIDTH];
               end
            end
         end

         MUL: begin
            if (mul_done) begin
               acc_d    = product[WIDTH-1:0];
               acc_hi_d = product[2*WIDTH-1:WIDTH];
               c_d      = (product[2*WIDTH-1:WIDTH] != '0);
               done_d   = 1'b1;
               state_d  = IDLE;
            end else if (!mul_busy) begin
               // Defensive: never strand the sequencer if the multiplier idles.
               state_d = IDLE;
            end
         end

         SHIFT: begin
            work_d  = shifted;
            shcnt_d = shcnt_q - SHW'(1);
            if (shcnt_q == SHW'(1)) begin
               acc_d   = shifted;
               c_d     = bit_out;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase

      if (done_d && !illegal_d) begin
         z_d = (acc_d == '0);
         n_d = acc_d[WIDTH-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         acc_hi_q  <= '0;
         c_q       <= 1'b0;
         z_q       <= 1'b0;
         n_q       <= 1'b0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         work_q    <= '0;
         shcnt_q   <= '0;
         shr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         acc_hi_q  <= acc_hi_d;
         c_q       <= c_d;
         z_q       <= z_d;
         n_q       <= n_d;
         done_q    <= done_d;
         illegal_q <= illegal_d;
         work_q    <= work_d;
         shcnt_q   <= shcnt_d;
         shr_q     <= shr_d;
      end
   end

   assign bus.op_ready = (state_q == IDLE);
   assign bus.done     = done_q;
   assign bus.illegal  = illegal_q;
   assign bus.acc      = acc_q;
   assign bus.acc_hi   = acc_hi_q;
   assign bus.flag_c   = c_q;
   assign bus.flag_z   = z_q;
   assign bus.flag_n   = n_q;
endmodule

// File: doc/alu_accu_seq.md
Name: alu_accu_seq

Overview:
- Parametrised, registered successor to the combinational 8-bit ALU used in the uProcessor datapath.
- Owns the accumulator and the C/Z/N status flags.
- Executes single-cycle arithmetic/logic ops and multi-cycle multiply and barrel-free shifts, under a valid/ready handshake with the control unit.
- Sits between the instruction decoder (op source) and the data memory read port (operand source).

Parameters:
- WIDTH, 8, datapath width in bits (>=4).
- SHW, $clog2(WIDTH), shift-amount field width taken from operand[SHW-1:0].

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op_valid  in  1  request; op accepted at rising edge when op_valid && op_ready.
- op_code  in  4  operation select (see Behaviour).
- operand  in  WIDTH  memory/register operand B.
- op_ready  out  1  high when idle; combinational from state.
- done  out  1  one-cycle pulse: result, flags and acc_hi now valid.
- illegal  out  1  one-cycle pulse with done for an unknown op_code.
- acc  out  WIDTH  accumulator A (registered).
- acc_hi  out  WIDTH  high word of last MUL; unchanged by all other ops.
- flag_c  out  1  carry/borrow/shift-out flag.
- flag_z  out  1  result == 0.
- flag_n  out  1  result MSB.

Behaviour:
- Reset (async, rst_n=0): acc=0, acc_hi=0, flags=0, done=0, illegal=0, state=IDLE, op_ready=1. Reset mid-operation aborts the op; no done is produced.
- States:
  - IDLE: accepts ops.
  - MUL: WIDTH iterations.
  - SHIFT: shamt iterations.
  - IDLE is re-entered at the edge that writes the result.
- op_code map:
  - 0 ADD: A+B.
  - 1 ADC: A+B+C.
  - 2 SUB: A-B.
  - 3 SBC: A-B-C.
  - 4 AND.
  - 5 OR.
  - 6 XOR.
  - 7 NOT: ~A.
  - 8 LD: A=B.
  - 9 MUL.
  - 10 SHL.
  - 11 SHR (logical).
  - 12 CLR: A=0.
  - 13-15 illegal.
- Arithmetic: computed at WIDTH+1 bits; C = bit WIDTH. For SUB/SBC, C=1 means borrow (A < B+Cin unsigned).
- Logic, NOT, LD, CLR: C cleared.
- Z and N are updated from the new acc for every legal op.
- Single-cycle ops (0-8, 12): accepted at edge k, acc/flags written at edge k, done=1 for cycle k..k+1.
- MUL:
  - Unsigned shift-add. Operands latched at acceptance; op_ready=0 for WIDTH cycles.
  - At edge k+WIDTH: acc = product[WIDTH-1:0], acc_hi = product[2W-1:W], C = (acc_hi != 0), Z/N from acc. done pulses the following cycle.
- SHL/SHR:
  - shamt = operand[SHW-1:0]; one bit per cycle; C = last bit shifted out.
  - shamt=0 completes as a single-cycle op: acc unchanged, C cleared, Z/N refreshed.
  - Result written at edge k+shamt.
- Illegal op: acc/flags/acc_hi unchanged; done and illegal pulse together as for a single-cycle op.
- op_valid while op_ready=0 is ignored; the requester must hold it.
- Back-to-back: op_ready is high in the same cycle as done, so a new op may be accepted at the very next edge.
- op_code/operand values are don't-care when not accepted.

Decomposition:
- Package alu_pkg:
  - op_e enum (4-bit, values above).
  - state_e enum {IDLE, MUL, SHIFT}.
  - Localparam ALU_OPW=4.
- Sub-module alu_mul_seq:
  - Start/busy/done shift-add multiplier with WIDTH parameter, async active-low reset.
  - Instantiated once; the top FSM sequences it.

Test Plan (WIDTH=8):
1. Reset, then ADD 0x7F then ADC 0x80 with C=0 -> acc=0xFF, C=0, N=1, Z=0. Next ADC 0x01 -> acc=0x00, C=1, Z=1.
2. LD 0x05, SUB 0x07 -> acc=0xFE, C=1 (borrow), N=1. Next SBC 0x00 -> acc=0xFD, C=0.
3. LD 0xFF, MUL 0xFF -> op_ready low 8 cycles, then acc=0x01, acc_hi=0xFE, C=1, done one cycle. Next MUL 0x00 -> acc=0x00, acc_hi=0x00, Z=1, C=0.
4. LD 0x81, SHL 3 -> done 3 cycles after acceptance, acc=0x08, C=0. Then SHR 4 -> acc=0x00, C=1, Z=1. Then SHL 0 -> single cycle, acc unchanged, C=0.
5. op_code 14 with acc=0x3C -> done=1 and illegal=1 for one cycle, acc/flags unchanged. op_valid pulsed during a MUL -> ignored, no extra done.
6. Start MUL, assert rst_n=0 at busy cycle 4 -> all outputs immediately zero, op_ready=1, no done. After release, AND 0xF0 with acc=0 -> acc=0x00, Z=1.
